// File: rtl/nec_ir_pkg.sv
// Shared types and constants for the NEC IR receiver: FSM states, frame size, byte-lane helpers.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    RPT_MARK,
    CHECK
  } nec_state_t;

  localparam int NEC_BITS = 32;

  // Byte lanes of the 32-bit frame, in transmission order
  localparam int LANE_ADDR_LO = 0;
  localparam int LANE_ADDR_HI = 1;
  localparam int LANE_CMD     = 2;
  localparam int LANE_CMD_INV = 3;

  function automatic logic [7:0] frame_byte(input logic [31:0] frame, input int lane);
    return frame[lane*8 +: 8];
  endfunction

  function automatic logic byte_pair_ok(input logic [7:0] plain, input logic [7:0] inv);
    return inv == ~plain;
  endfunction

endpackage

// File: rtl/nec_ir_receiver_if.sv
// Decoded-frame output bundle of the NEC receiver; master drives, slave (LED/display logic) consumes.
interface nec_ir_receiver_if;
  logic [15:0] addr_o;
  logic [7:0]  cmd_o;
  logic        valid_o;
  logic        repeat_o;
  logic        err_o;
  logic        busy_o;

  modport master (output addr_o, cmd_o, valid_o, repeat_o, err_o, busy_o);
  modport slave  (input  addr_o, cmd_o, valid_o, repeat_o, err_o, busy_o);
endinterface

// File: rtl/nec_ir_receiver_sync_edge.sv
// Reusable IR input synchroniser (module ir_sync_edge) with single-cycle rise/fall strobes.
// Strobes appear SYNC_STAGES cycles after the input edge; stages reset to the idle line level.
module ir_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      level_q <= IDLE_LEVEL;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_q <= level;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_q;
  assign fall  = ~level & level_q;

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame receiver: valid_o/err_o 2 cycles after the synchronised stop-mark rise, no backpressure.
// Repeat-frame detection (repeat_o, have_last) is built only when NEC_REPEAT_EN is defined.
module nec_ir_receiver
  import nec_ir_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int LEAD_MARK_MIN  = 400000,
  parameter int DATA_SPACE_MIN = 175000,
  parameter int RPT_SPACE_MIN  = 87500,
  parameter int MARK_MAX       = 50000,
  parameter int ONE_THRESH     = 56000,
  parameter int TIMEOUT        = 550000,
  parameter int ADDR_STRICT    = 1
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              IRDA_RXD,
  nec_ir_receiver_if.master ir
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LEAD_MIN_C = CW'(LEAD_MARK_MIN);
  localparam logic [CW-1:0] DATA_MIN_C = CW'(DATA_SPACE_MIN);
  localparam logic [CW-1:0] RPT_MIN_C  = CW'(RPT_SPACE_MIN);
  localparam logic [CW-1:0] MARK_MAX_C = CW'(MARK_MAX);
  localparam logic [CW-1:0] ONE_C      = CW'(ONE_THRESH);
  localparam logic [5:0]    LAST_BIT   = 6'(NEC_BITS);

  nec_state_t state_q, state_d;

  logic          rx_rise, rx_fall;
  logic [CW-1:0] cnt_q;
  logic [5:0]    bitcnt_q;
  logic [31:0]   shreg_q;
  logic          timeout;
  logic          frame_ok;
  logic [7:0]    byte0, byte1, byte2, byte3;

  logic          ev_valid, ev_err, clr_frame, shift_en;
  logic [15:0]   addr_q;
  logic [7:0]    cmd_q;
  logic          valid_q, err_q, busy_q;

`ifdef NEC_REPEAT_EN
  logic          ev_rpt;
  logic          rpt_q;
  logic          have_last_q;
`endif

  ir_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE_LEVEL (1'b1)
  ) u_sync (
    .clk  (CLOCK_50),
    .rst_n(RESET_N),
    .din  (IRDA_RXD),
    .rise (rx_rise),
    .fall (rx_fall)
  );

  assign byte0    = frame_byte(shreg_q, LANE_ADDR_LO);
  assign byte1    = frame_byte(shreg_q, LANE_ADDR_HI);
  assign byte2    = frame_byte(shreg_q, LANE_CMD);
  assign byte3    = frame_byte(shreg_q, LANE_CMD_INV);
  assign frame_ok = byte_pair_ok(byte2, byte3) &&
                    ((ADDR_STRICT == 0) || byte_pair_ok(byte0, byte1));
  assign timeout  = (state_q != IDLE) && (cnt_q == TIMEOUT_C);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:       if (rx_fall) state_d = LEAD_MARK;
        LEAD_MARK:  if (rx_rise) state_d = (cnt_q >= LEAD_MIN_C) ? LEAD_SPACE : IDLE;
        LEAD_SPACE: if (rx_fall) begin
          if (cnt_q >= DATA_MIN_C) state_d = BIT_MARK;
`ifdef NEC_REPEAT_EN
          else if (cnt_q >= RPT_MIN_C) state_d = RPT_MARK;
`endif
          else state_d = IDLE;
        end
        BIT_MARK:   if (rx_rise) begin
          if (cnt_q > MARK_MAX_C)         state_d = IDLE;
          else if (bitcnt_q == LAST_BIT)  state_d = CHECK;
          else                            state_d = BIT_SPACE;
        end
        BIT_SPACE:  if (rx_fall) state_d = BIT_MARK;
        RPT_MARK:   if (rx_rise) state_d = IDLE;
        CHECK:      state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ev_valid  = 1'b0;
    ev_err    = 1'b0;
    clr_frame = 1'b0;
    shift_en  = 1'b0;
`ifdef NEC_REPEAT_EN
    ev_rpt    = 1'b0;
`endif
    if (timeout) begin
      ev_err = 1'b1;
    end else begin
      case (state_q)
        LEAD_MARK:  ev_err = rx_rise && (cnt_q < LEAD_MIN_C);
        // A repeat-length space is never an error; without repeat support it is just dropped
        LEAD_SPACE: if (rx_fall) begin
          if (cnt_q >= DATA_MIN_C)    clr_frame = 1'b1;
          else if (cnt_q < RPT_MIN_C) ev_err    = 1'b1;
        end
        BIT_MARK:   ev_err   = rx_rise && (cnt_q > MARK_MAX_C);
        BIT_SPACE:  shift_en = rx_fall;
        RPT_MARK:   if (rx_rise) begin
          if (cnt_q > MARK_MAX_C) ev_err = 1'b1;
`ifdef NEC_REPEAT_EN
          else                    ev_rpt = have_last_q;
`endif
        end
        CHECK: begin
          ev_valid = frame_ok;
          ev_err   = !frame_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (rx_rise || rx_fall)     cnt_q <= '0;
      else if (cnt_q != TIMEOUT_C) cnt_q <= cnt_q + 1'b1;

      if (clr_frame) begin
        bitcnt_q <= '0;
        shreg_q  <= '0;
      end else if (shift_en) begin
        shreg_q[bitcnt_q[4:0]] <= (cnt_q >= ONE_C);
        bitcnt_q               <= bitcnt_q + 1'b1;
      end

      if (ev_valid) begin
        addr_q <= (ADDR_STRICT != 0) ? {8'h00, byte0} : {byte1, byte0};
        cmd_q  <= byte2;
      end

      valid_q <= ev_valid;
      err_q   <= ev_err;
      // Registered from the current state so busy_o falls the cycle after an abort strobe
      busy_q  <= (state_q != IDLE);
    end
  end

`ifdef NEC_REPEAT_EN
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rpt_q       <= 1'b0;
      have_last_q <= 1'b0;
    end else begin
      rpt_q <= ev_rpt;
      if (ev_valid)    have_last_q <= 1'b1;
      else if (ev_err) have_last_q <= 1'b0;
    end
  end

  assign ir.repeat_o = rpt_q;
`else
  assign ir.repeat_o = 1'b0;
`endif

  assign ir.addr_o  = addr_q;
  assign ir.cmd_o   = cmd_q;
  assign ir.valid_o = valid_q;
  assign ir.err_o   = err_q;
  assign ir.busy_o  = busy_q;

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Bench for nec_ir_receiver: a strict-address and an extended-address instance share one IR line,
// driven with directed and randomized frames and checked against a frame-level reference model.
module tb_nec_ir_receiver;

  localparam int LEAD_MIN = 80;
  localparam int DATA_MIN = 35;
  localparam int RPT_MIN  = 17;
  localparam int MARK_MX  = 10;
  localparam int ONE_TH   = 11;
  localparam int TOUT     = 110;
  localparam int SYNC_S   = 2;
  localparam int SYNC_E   = 3;
`ifdef NEC_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  logic IRDA_RXD = 1'b1;
  int   cyc      = 0;

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  nec_ir_receiver_if if_s ();
  nec_ir_receiver_if if_e ();

  nec_ir_receiver #(
    .SYNC_STAGES(SYNC_S), .LEAD_MARK_MIN(LEAD_MIN), .DATA_SPACE_MIN(DATA_MIN),
    .RPT_SPACE_MIN(RPT_MIN), .MARK_MAX(MARK_MX), .ONE_THRESH(ONE_TH),
    .TIMEOUT(TOUT), .ADDR_STRICT(1)
  ) u_dut_strict (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .IRDA_RXD(IRDA_RXD), .ir(if_s)
  );

  nec_ir_receiver #(
    .SYNC_STAGES(SYNC_E), .LEAD_MARK_MIN(LEAD_MIN), .DATA_SPACE_MIN(DATA_MIN),
    .RPT_SPACE_MIN(RPT_MIN), .MARK_MAX(MARK_MX), .ONE_THRESH(ONE_TH),
    .TIMEOUT(TOUT), .ADDR_STRICT(0)
  ) u_dut_ext (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .IRDA_RXD(IRDA_RXD), .ir(if_e)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state, index 0 = strict instance, 1 = extended instance
  logic [15:0] m_addr[2];
  logic [7:0]  m_cmd[2];
  bit          m_have[2];
  int          sync_of[2]   = '{SYNC_S, SYNC_E};
  bit          strict_of[2] = '{1'b1, 1'b0};

  // Strobe monitor: counts high cycles of each strobe and timestamps them
  int n_val[2], n_err[2], n_rep[2];
  int t_val[2], t_err[2];
  logic busy_at_err[2], busy_after_err[2];
  bit   pend[2];
  int   s_val[2], s_err[2], s_rep[2];

  task automatic mon(input int d, input logic v, input logic e, input logic r, input logic b);
    int hot;
    if (pend[d]) begin
      busy_after_err[d] = b;
      pend[d] = 1'b0;
    end
    if (v) begin n_val[d]++; t_val[d] = cyc; end
    if (e) begin n_err[d]++; t_err[d] = cyc; busy_at_err[d] = b; pend[d] = 1'b1; end
    if (r) n_rep[d]++;
    hot = int'(v) + int'(e) + int'(r);
    if (hot != 0) chk_eq($sformatf("strobe_onehot%0d", d), hot, 1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      n_val[d] = 0; n_err[d] = 0; n_rep[d] = 0; t_val[d] = 0; t_err[d] = 0; pend[d] = 1'b0;
      m_addr[d] = '0; m_cmd[d] = '0; m_have[d] = 1'b0;
    end
  end

  always @(negedge CLOCK_50) begin
    mon(0, if_s.valid_o, if_s.err_o, if_s.repeat_o, if_s.busy_o);
    mon(1, if_e.valid_o, if_e.err_o, if_e.repeat_o, if_e.busy_o);
  end

  function automatic int rr(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic hold(input logic v, input int n);
    IRDA_RXD = v;
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      s_val[d] = n_val[d]; s_err[d] = n_err[d]; s_rep[d] = n_rep[d];
    end
  endtask

  task automatic send_leader(input bit rpt);
    hold(1'b0, rr(85, 95));
    hold(1'b1, rpt ? rr(20, 26) : rr(40, 50));
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, rr(4, 8));
      hold(1'b1, w[i] ? rr(14, 20) : rr(4, 8));
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_eq({tag, "_addr_s"}, if_s.addr_o, m_addr[0]);
    chk_eq({tag, "_cmd_s"},  if_s.cmd_o,  m_cmd[0]);
    chk_eq({tag, "_addr_e"}, if_e.addr_o, m_addr[1]);
    chk_eq({tag, "_cmd_e"},  if_e.cmd_o,  m_cmd[1]);
    chk_eq({tag, "_busy_s"}, if_s.busy_o, 1'b0);
    chk_eq({tag, "_busy_e"}, if_e.busy_o, 1'b0);
  endtask

  task automatic data_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    int t_stop;
    bit ok;
    snap();
    send_leader(1'b0);
    send_bits({b3, b2, b1, b0}, 32);
    hold(1'b0, rr(4, 8));
    t_stop = cyc;
    hold(1'b1, 60);
    for (int d = 0; d < 2; d++) begin
      ok = (b3 == ~b2) && (!strict_of[d] || (b1 == ~b0));
      chk_eq($sformatf("%s_valid%0d", tag, d), n_val[d] - s_val[d], ok);
      chk_eq($sformatf("%s_err%0d", tag, d), n_err[d] - s_err[d], !ok);
      chk_eq($sformatf("%s_rep%0d", tag, d), n_rep[d] - s_rep[d], 0);
      chk_eq($sformatf("%s_lat%0d", tag, d), (ok ? t_val[d] : t_err[d]) - t_stop, sync_of[d] + 2);
      if (ok) begin
        m_addr[d] = strict_of[d] ? {8'h00, b0} : {b1, b0};
        m_cmd[d]  = b2;
        m_have[d] = 1'b1;
      end else begin
        m_have[d] = 1'b0;
      end
    end
    chk_idle_outputs(tag);
  endtask

  task automatic repeat_frame(input string tag);
    snap();
    send_leader(1'b1);
    hold(1'b0, rr(4, 8));
    hold(1'b1, 60);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("%s_rep%0d", tag, d), n_rep[d] - s_rep[d], REP_EN && m_have[d]);
      chk_eq($sformatf("%s_err%0d", tag, d), n_err[d] - s_err[d], 0);
      chk_eq($sformatf("%s_valid%0d", tag, d), n_val[d] - s_val[d], 0);
    end
    chk_idle_outputs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=time_expired exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1, b2, b3;
    int t_drive;
    int kind;

    repeat (4) @(posedge CLOCK_50);
    #1;
    chk_idle_outputs("reset");
    chk_eq("reset_valid", {if_s.valid_o, if_s.err_o, if_s.repeat_o, if_e.valid_o, if_e.err_o, if_e.repeat_o}, 0);
    RESET_N = 1'b1;
    hold(1'b1, 20);

    data_frame("strict_45", 8'h00, 8'hFF, 8'h45, 8'hBA);
    repeat_frame("rpt_after_45");
    data_frame("ext_16", 8'h00, 8'hEF, 8'h16, 8'hE9);
    data_frame("bad_cmd", 8'h00, 8'hFF, 8'h45, 8'hBB);
    repeat_frame("rpt_after_bad");
    data_frame("strict_45b", 8'h00, 8'hFF, 8'h45, 8'hBA);

    // Line stuck high after the 10th bit mark
    snap();
    send_leader(1'b0);
    send_bits(32'h5AA5_3C96, 9);
    hold(1'b0, rr(4, 8));
    t_drive = cyc;
    hold(1'b1, 150);
    for (int d = 0; d < 2; d++) begin
      chk_eq($sformatf("tmo_err%0d", d), n_err[d] - s_err[d], 1);
      chk_eq($sformatf("tmo_lat%0d", d), t_err[d] - t_drive, TOUT + sync_of[d] + 2);
      chk_eq($sformatf("tmo_busy_at%0d", d), busy_at_err[d], 1'b1);
      chk_eq($sformatf("tmo_busy_next%0d", d), busy_after_err[d], 1'b0);
      m_have[d] = 1'b0;
    end
    chk_idle_outputs("tmo");
    repeat_frame("rpt_after_tmo");

    // Reset in the middle of bit 20
    data_frame("pre_rst", 8'h21, 8'hDE, 8'h7C, 8'h83);
    send_leader(1'b0);
    send_bits(32'hFFFF_FFFF, 20);
    hold(1'b0, 3);
    RESET_N  = 1'b0;
    IRDA_RXD = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      m_addr[d] = '0; m_cmd[d] = '0; m_have[d] = 1'b0;
    end
    chk_idle_outputs("mid_rst");
    chk_eq("mid_rst_strobes", {if_s.valid_o, if_s.err_o, if_s.repeat_o, if_e.valid_o, if_e.err_o, if_e.repeat_o}, 0);
    repeat (5) @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    hold(1'b1, 30);
    repeat_frame("rpt_after_rst");
    data_frame("post_rst", 8'h07, 8'hF8, 8'h19, 8'hE6);

    for (int i = 0; i < 12; i++) begin
      b0 = 8'($urandom);
      b2 = 8'($urandom);
      kind = rr(0, 3);
      b1 = (kind == 2) ? (~b0 ^ 8'(rr(1, 255))) : ~b0;
      b3 = (kind == 3) ? (~b2 ^ 8'(rr(1, 255))) : ~b2;
      if (kind == 0) b1 = 8'($urandom);
      data_frame($sformatf("rnd%0d", i), b0, b1, b2, b3);
      if (rr(0, 1) == 1) repeat_frame($sformatf("rnd_rpt%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
